rsa_modexp_core: RTL and testbench

RSA_MODEXP_CORE -- requirements
Module: rsa_modexp_core

---
 rtl/rsa_pkg.sv | 21 ++
 rtl/rsa_modmul.sv | 86 ++++++++
 rtl/rsa_modexp_core.sv | 166 ++++++++++++++++
 tb/tb_rsa_modexp_core.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation core.
package rsa_pkg;

  localparam int RSA_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_KEY  = 2'b10,
    MODE_RSVD = 2'b11
  } rsa_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    UPDATE,
    DONE
  } rsa_state_e;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: result = a*b mod n, one bit of b
// per cycle MSB first, finishing exactly WORD_WIDTH cycles after start.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WORD_WIDTH = RSA_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic [WORD_WIDTH-1:0] n_i,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  done
);

  localparam int IW = WORD_WIDTH + 2;
  localparam int CW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WORD_WIDTH - 1);

  logic [IW-1:0]         p_reg;
  logic [WORD_WIDTH-1:0] a_reg;
  logic [WORD_WIDTH-1:0] b_reg;
  logic [WORD_WIDTH-1:0] n_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  run_reg;
  logic                  done_reg;

  logic [IW-1:0] p_cur;
  logic [IW-1:0] a_cur;
  logic [IW-1:0] n_cur;
  logic [IW-1:0] sum;
  logic [IW-1:0] sub1;
  logic [IW-1:0] p_next;
  logic          b_bit;

  // The start cycle already performs the first step straight from the inputs,
  // so the whole product takes WORD_WIDTH edges with no setup cycle.
  // With p < n and a < n, 2p + a < 3n, so two subtractions always suffice.
  always_comb begin
    p_cur  = start ? '0 : p_reg;
    a_cur  = IW'(start ? a_i : a_reg);
    n_cur  = IW'(start ? n_i : n_reg);
    b_bit  = start ? b_i[WORD_WIDTH-1] : b_reg[WORD_WIDTH-1];
    sum    = (p_cur << 1) + (b_bit ? a_cur : '0);
    sub1   = (sum >= n_cur) ? (sum - n_cur) : sum;
    p_next = (sub1 >= n_cur) ? (sub1 - n_cur) : sub1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_reg    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      n_reg    <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        p_reg   <= p_next;
        a_reg   <= a_i;
        b_reg   <= b_i << 1;
        n_reg   <= n_i;
        cnt_reg <= CW'(1);
        run_reg <= 1'b1;
      end else if (run_reg) begin
        p_reg <= p_next;
        b_reg <= b_reg << 1;
        if (cnt_reg == LAST_STEP) begin
          cnt_reg  <= '0;
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  end

  assign result = p_reg[WORD_WIDTH-1:0];
  assign done   = done_reg;

endmodule

// File: rtl/rsa_modexp_core.sv
// Constant-time RSA modular exponentiation (right-to-left square-and-multiply)
// with an on-chip key register set.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WORD_WIDTH = RSA_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [WORD_WIDTH-1:0] message_i,
  input  logic [WORD_WIDTH-1:0] e_i,
  input  logic [WORD_WIDTH-1:0] d_i,
  input  logic [WORD_WIDTH-1:0] N_i,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WORD_WIDTH-1:0] message_o,
  output logic [WORD_WIDTH-1:0] e_o,
  output logic [WORD_WIDTH-1:0] d_o,
  output logic [WORD_WIDTH-1:0] N_o
);

  localparam int CW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0]         LAST_STEP = CW'(WORD_WIDTH - 1);
  localparam logic [WORD_WIDTH-1:0] MIN_MOD   = WORD_WIDTH'(2);

  rsa_state_e            state_reg;
  rsa_mode_e             mode_reg;
  logic [WORD_WIDTH-1:0] msg_reg;
  logic [WORD_WIDTH-1:0] acc_reg;
  logic [WORD_WIDTH-1:0] base_reg;
  logic [WORD_WIDTH-1:0] exp_reg;
  logic [CW-1:0]         bit_cnt_reg;
  logic [CW-1:0]         mul_cnt_reg;
  logic                  key_valid_reg;
  logic                  err_reg;
  logic                  mm_start_reg;

  logic [WORD_WIDTH-1:0] mm_a      [2];
  logic [WORD_WIDTH-1:0] mm_result [2];
  logic [1:0]            mm_done;

  // Unit 0 forms acc*base, unit 1 forms base*base; both always run so every
  // exponent bit costs the same number of cycles.
  assign mm_a[0] = acc_reg;
  assign mm_a[1] = base_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mm
      rsa_modmul #(
        .WORD_WIDTH(WORD_WIDTH)
      ) u_mm (
        .clk    (clk),
        .rst    (rst),
        .start  (mm_start_reg),
        .a_i    (mm_a[gi]),
        .b_i    (base_reg),
        .n_i    (N_o),
        .result (mm_result[gi]),
        .done   (mm_done[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      mode_reg      <= MODE_ENC;
      msg_reg       <= '0;
      acc_reg       <= '0;
      base_reg      <= '0;
      exp_reg       <= '0;
      bit_cnt_reg   <= '0;
      mul_cnt_reg   <= '0;
      key_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      mm_start_reg  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      message_o     <= '0;
      e_o           <= '0;
      d_o           <= '0;
      N_o           <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done  <= 1'b0;
          error <= 1'b0;
          busy  <= start;
          if (start) begin
            mode_reg  <= rsa_mode_e'(mode);
            msg_reg   <= message_i;
            state_reg <= LOAD;
          end
        end

        LOAD: begin
          err_reg   <= 1'b1;
          state_reg <= DONE;
          if (mode_reg == MODE_KEY) begin
            if (N_i >= MIN_MOD) begin
              e_o           <= e_i;
              d_o           <= d_i;
              N_o           <= N_i;
              key_valid_reg <= 1'b1;
              err_reg       <= 1'b0;
            end
          end else if (mode_reg != MODE_RSVD && key_valid_reg && msg_reg < N_o) begin
            err_reg      <= 1'b0;
            acc_reg      <= WORD_WIDTH'(1);
            base_reg     <= msg_reg;
            exp_reg      <= (mode_reg == MODE_ENC) ? e_o : d_o;
            bit_cnt_reg  <= '0;
            mul_cnt_reg  <= '0;
            mm_start_reg <= 1'b1;
            state_reg    <= MUL;
          end
        end

        MUL: begin
          mm_start_reg <= 1'b0;
          if (mul_cnt_reg == LAST_STEP) begin
            mul_cnt_reg <= '0;
            state_reg   <= UPDATE;
          end else begin
            mul_cnt_reg <= mul_cnt_reg + CW'(1);
          end
        end

        UPDATE: begin
          if (&mm_done) begin
            base_reg <= mm_result[1];
            if (exp_reg[0]) begin
              acc_reg <= mm_result[0];
            end
          end
          exp_reg     <= exp_reg >> 1;
          bit_cnt_reg <= bit_cnt_reg + CW'(1);
          if (bit_cnt_reg == LAST_STEP) begin
            state_reg <= DONE;
          end else begin
            mm_start_reg <= 1'b1;
            state_reg    <= MUL;
          end
        end

        DONE: begin
          done  <= 1'b1;
          error <= err_reg;
          // A key load, successful or not, leaves the last result visible.
          if (mode_reg != MODE_KEY) begin
            message_o <= err_reg ? '0 : acc_reg;
          end
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed bench for rsa_modexp_core: vector table plus start/reset corner cases.
module tb_rsa_modexp_core;
  import rsa_pkg::*;

  localparam int W    = 32;
  localparam int LONG = 2 + W * (W + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] message_i = '0;
  logic [W-1:0] e_i = '0;
  logic [W-1:0] d_i = '0;
  logic [W-1:0] N_i = '0;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] message_o;
  logic [W-1:0] e_o;
  logic [W-1:0] d_o;
  logic [W-1:0] N_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rsa_modexp_core #(.WORD_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .message_i (message_i),
    .e_i       (e_i),
    .d_i       (d_i),
    .N_i       (N_i),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .message_o (message_o),
    .e_o       (e_o),
    .d_o       (d_o),
    .N_o       (N_o)
  );

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] msg;
    logic [W-1:0] ek;
    logic [W-1:0] dk;
    logic [W-1:0] nk;
    int           lat;
    bit           err;
    logic [W-1:0] res;
    logic [W-1:0] xe;
    logic [W-1:0] xd;
    logic [W-1:0] xn;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Issue one operation, scramble mode/message after accept, and count
  // cycles from the accept edge until done (bounded).
  task automatic run_op(input logic [1:0] m, input logic [W-1:0] msg,
                        input logic [W-1:0] ek, input logic [W-1:0] dk,
                        input logic [W-1:0] nk, output int lat, output bit bok);
    mode = m; message_i = msg; e_i = ek; d_i = dk; N_i = nk; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; message_i = ~msg;
    lat = 0; bok = 1'b1;
    while (lat < LONG + 20) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) bok = 1'b0;
      if (done) break;
    end
  endtask

  initial begin
    int lat;
    bit bok;
    int cnt;
    int dones;
    int first;
    int second;

    // Key 17/2753/3233 is the textbook 61*53 pair; 4294967291 = 2^32-5 is prime.
    vecs.push_back('{MODE_ENC,  65,   0,  0,    0,    2,    1'b1, 0,    0,  0,    0});
    vecs.push_back('{MODE_KEY,  0,    17, 2753, 3233, 2,    1'b0, 0,    17, 2753, 3233});
    vecs.push_back('{MODE_ENC,  65,   0,  0,    0,    LONG, 1'b0, 2790, 17, 2753, 3233});
    vecs.push_back('{MODE_DEC,  2790, 0,  0,    0,    LONG, 1'b0, 65,   17, 2753, 3233});
    vecs.push_back('{MODE_KEY,  0,    5,  7,    1,    2,    1'b1, 65,   17, 2753, 3233});
    vecs.push_back('{MODE_ENC,  3233, 0,  0,    0,    2,    1'b1, 0,    17, 2753, 3233});
    vecs.push_back('{MODE_RSVD, 5,    0,  0,    0,    2,    1'b1, 0,    17, 2753, 3233});
    vecs.push_back('{MODE_DEC,  3232, 0,  0,    0,    LONG, 1'b0, 3232, 17, 2753, 3233});
    vecs.push_back('{MODE_ENC,  0,    0,  0,    0,    LONG, 1'b0, 0,    17, 2753, 3233});
    vecs.push_back('{MODE_KEY,  0,    0,  0,    3233, 2,    1'b0, 0,    0,  0,    3233});
    vecs.push_back('{MODE_DEC,  1234, 0,  0,    0,    LONG, 1'b0, 1,    0,  0,    3233});
    vecs.push_back('{MODE_ENC,  1234, 0,  0,    0,    LONG, 1'b0, 1,    0,  0,    3233});
    vecs.push_back('{MODE_KEY,  0,    2,  32,   32'hFFFFFFFB, 2, 1'b0, 1, 2, 32, 32'hFFFFFFFB});
    vecs.push_back('{MODE_ENC,  32'hFFFFFFFA, 0, 0, 0, LONG, 1'b0, 1,   2,  32,   32'hFFFFFFFB});
    vecs.push_back('{MODE_DEC,  2,    0,  0,    0,    LONG, 1'b0, 5,    2,  32,   32'hFFFFFFFB});
    vecs.push_back('{MODE_ENC,  32'hFFFFFFF0, 0, 0, 0, LONG, 1'b0, 121, 2,  32,   32'hFFFFFFFB});
    vecs.push_back('{MODE_ENC,  32'hFFFFFFFB, 0, 0, 0, 2,    1'b1, 0,   2,  32,   32'hFFFFFFFB});

    #2 rst = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_message_o", message_o, 0);
    check("reset_e_o", e_o, 0);
    check("reset_d_o", d_o, 0);
    check("reset_N_o", N_o, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].m, vecs[i].msg, vecs[i].ek, vecs[i].dk, vecs[i].nk, lat, bok);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_held", i), bok, 1);
      check($sformatf("v%0d_error", i), error, vecs[i].err);
      check($sformatf("v%0d_message_o", i), message_o, vecs[i].res);
      check($sformatf("v%0d_e_o", i), e_o, vecs[i].xe);
      check($sformatf("v%0d_d_o", i), d_o, vecs[i].xd);
      check($sformatf("v%0d_N_o", i), N_o, vecs[i].xn);
      @(posedge clk); #1;
      check($sformatf("v%0d_busy_done_after", i), {busy, done}, 0);
    end

    // start held through DONE: a second key load is accepted right after.
    mode = MODE_KEY; e_i = 17; d_i = 2753; N_i = 3233; start = 1'b1;
    @(posedge clk); #1;
    first = 0; second = 0; bok = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 3) start = 1'b0;
      if (done && first == 0) first = c;
      else if (done) second = c;
      if (c <= 5 && !busy) bok = 1'b0;
      if (c == 6) check("held_busy_drop", busy, 0);
    end
    check("held_first_done", first, 2);
    check("held_second_done", second, 5);
    check("held_busy_continuous", bok, 1);
    check("held_N_o", N_o, 3233);

    // start asserted every cycle of an encrypt, with noise on mode/message.
    mode = MODE_ENC; message_i = 65; start = 1'b1;
    @(posedge clk); #1;
    cnt = 0; dones = 0; first = 0; bok = 1'b1;
    while (cnt < LONG + 10) begin
      if (cnt < LONG - 5) begin
        start = 1'b1;
        mode = 2'($urandom_range(0, 3));
        message_i = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
      if (done) begin
        dones++;
        if (first == 0) first = cnt;
      end
      if (first == 0 && !busy) bok = 1'b0;
    end
    check("spam_done_count", dones, 1);
    check("spam_latency", first, LONG);
    check("spam_busy_continuous", bok, 1);
    check("spam_message_o", message_o, 2790);
    check("spam_e_o", e_o, 17);

    // Reset 500 cycles into an encrypt: outputs clear at once, no done.
    mode = MODE_ENC; message_i = 65; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (500) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_message_o", message_o, 0);
    check("abort_e_o", e_o, 0);
    check("abort_d_o", d_o, 0);
    check("abort_N_o", N_o, 0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    rst = 1'b1;
    repeat (1100) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(MODE_ENC, 65, 0, 0, 0, lat, bok);
    check("post_reset_latency", lat, 2);
    check("post_reset_error", error, 1);
    check("post_reset_message_o", message_o, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
